// File: rtl/regfile_wb_scoreboard.sv
// rtl/regfile_wb_scoreboard.sv - 32x32 register file with writeback bypass and pending-write scoreboard
// Reads bypass the in-flight writeback; per-register counters gate issue on unresolved writes.
module regfile_wb_scoreboard #(
   parameter int PEND_W = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wb_wren_i,
   input  logic [4:0]  wb_addr_i,
   input  logic [31:0] wb_data_i,
   input  logic [4:0]  rs1_addr_i,
   input  logic [4:0]  rs2_addr_i,
   output logic [31:0] rs1_data_o,
   output logic [31:0] rs2_data_o,
   input  logic        issue_valid_i,
   input  logic        issue_rd_wren_i,
   input  logic [4:0]  issue_rd_addr_i,
   input  logic        rs1_used_i,
   input  logic        rs2_used_i,
   input  logic        kill_valid_i,
   input  logic [4:0]  kill_rd_addr_i,
   output logic        stall_o,
   output logic        sb_err_o
);

   localparam int                    DW       = PEND_W + 2;
   localparam logic [PEND_W-1:0]     CNT_MAX  = '1;
   localparam logic [PEND_W-1:0]     CNT_ONE  = PEND_W'(1);
   localparam logic signed [DW-1:0]  S_ONE    = DW'(1);
   localparam logic signed [DW-1:0]  S_ZERO   = '0;
   localparam logic signed [DW-1:0]  S_MAX    = $signed({2'b00, CNT_MAX});

   logic [31:0]       r_regs  [32];
   logic [PEND_W-1:0] r_count [32];
   logic              r_sb_err;

   logic              w_wb_hit;
   logic              w_kill_hit;
   logic              w_rs1_haz;
   logic              w_rs2_haz;
   logic              w_dst_haz;
   logic              w_stall;
   logic              w_issue_inc;
   logic [PEND_W-1:0] w_cnt_rs1;
   logic [PEND_W-1:0] w_cnt_rs2;
   logic [PEND_W-1:0] w_cnt_rd;
   logic [PEND_W-1:0] w_count_nxt [32];
   logic              w_err_set;
   logic signed [DW-1:0] w_sum;

   assign w_wb_hit   = wb_wren_i && (wb_addr_i != 5'd0);
   assign w_kill_hit = kill_valid_i && (kill_rd_addr_i != 5'd0);

   always_comb begin
      rs1_data_o = '0;
      if (rs1_addr_i != 5'd0) begin
         if (w_wb_hit && (wb_addr_i == rs1_addr_i)) rs1_data_o = wb_data_i;
         else                                      rs1_data_o = r_regs[rs1_addr_i];
      end
   end

   always_comb begin
      rs2_data_o = '0;
      if (rs2_addr_i != 5'd0) begin
         if (w_wb_hit && (wb_addr_i == rs2_addr_i)) rs2_data_o = wb_data_i;
         else                                      rs2_data_o = r_regs[rs2_addr_i];
      end
   end

   assign w_cnt_rs1 = r_count[rs1_addr_i];
   assign w_cnt_rs2 = r_count[rs2_addr_i];
   assign w_cnt_rd  = r_count[issue_rd_addr_i];

   // A single outstanding write is resolved if its writeback lands this very cycle.
   assign w_rs1_haz = rs1_used_i && (rs1_addr_i != 5'd0) &&
                      ((w_cnt_rs1 > CNT_ONE) ||
                       ((w_cnt_rs1 == CNT_ONE) && !(w_wb_hit && (wb_addr_i == rs1_addr_i))));
   assign w_rs2_haz = rs2_used_i && (rs2_addr_i != 5'd0) &&
                      ((w_cnt_rs2 > CNT_ONE) ||
                       ((w_cnt_rs2 == CNT_ONE) && !(w_wb_hit && (wb_addr_i == rs2_addr_i))));
   assign w_dst_haz = issue_rd_wren_i && (issue_rd_addr_i != 5'd0) && (w_cnt_rd == CNT_MAX) &&
                      !(w_wb_hit && (wb_addr_i == issue_rd_addr_i)) &&
                      !(w_kill_hit && (kill_rd_addr_i == issue_rd_addr_i));

   assign w_stall     = issue_valid_i && (w_rs1_haz || w_rs2_haz || w_dst_haz);
   assign w_issue_inc = issue_valid_i && !w_stall && issue_rd_wren_i && (issue_rd_addr_i != 5'd0);
   assign stall_o     = w_stall;
   assign sb_err_o    = r_sb_err;

   // Net delta per register, then clamp into 0..CNT_MAX and flag the clamp.
   always_comb begin
      w_err_set = 1'b0;
      w_sum     = S_ZERO;
      for (int i = 0; i < 32; i++) begin
         w_count_nxt[i] = '0;
         if (i != 0) begin
            w_sum = $signed({2'b00, r_count[i]});
            if (w_issue_inc && (issue_rd_addr_i == 5'(i))) w_sum = w_sum + S_ONE;
            if (w_wb_hit && (wb_addr_i == 5'(i)))          w_sum = w_sum - S_ONE;
            if (w_kill_hit && (kill_rd_addr_i == 5'(i)))   w_sum = w_sum - S_ONE;
            if (w_sum < S_ZERO) begin
               w_count_nxt[i] = '0;
               w_err_set      = 1'b1;
            end else if (w_sum > S_MAX) begin
               w_count_nxt[i] = CNT_MAX;
               w_err_set      = 1'b1;
            end else begin
               w_count_nxt[i] = w_sum[PEND_W-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i]  <= '0;
            r_count[i] <= '0;
         end
         r_sb_err <= 1'b0;
      end else begin
         if (w_wb_hit) r_regs[wb_addr_i] <= wb_data_i;
         for (int i = 0; i < 32; i++) r_count[i] <= w_count_nxt[i];
         if (w_err_set) r_sb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// tb/tb_regfile_wb_scoreboard.sv - directed self-checking bench for regfile_wb_scoreboard
module tb_regfile_wb_scoreboard;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        wb_wren_i;
   logic [4:0]  wb_addr_i;
   logic [31:0] wb_data_i;
   logic [4:0]  rs1_addr_i;
   logic [4:0]  rs2_addr_i;
   logic [31:0] rs1_data_o;
   logic [31:0] rs2_data_o;
   logic        issue_valid_i;
   logic        issue_rd_wren_i;
   logic [4:0]  issue_rd_addr_i;
   logic        rs1_used_i;
   logic        rs2_used_i;
   logic        kill_valid_i;
   logic [4:0]  kill_rd_addr_i;
   logic        stall_o;
   logic        sb_err_o;

   int n_checks = 0;
   int n_errors = 0;

   regfile_wb_scoreboard #(.PEND_W(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .wb_wren_i(wb_wren_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
      .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
      .issue_valid_i(issue_valid_i), .issue_rd_wren_i(issue_rd_wren_i),
      .issue_rd_addr_i(issue_rd_addr_i), .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
      .kill_valid_i(kill_valid_i), .kill_rd_addr_i(kill_rd_addr_i),
      .stall_o(stall_o), .sb_err_o(sb_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      wb_wren_i = 0; wb_addr_i = 0; wb_data_i = 0;
      rs1_addr_i = 0; rs2_addr_i = 0;
      issue_valid_i = 0; issue_rd_wren_i = 0; issue_rd_addr_i = 0;
      rs1_used_i = 0; rs2_used_i = 0;
      kill_valid_i = 0; kill_rd_addr_i = 0;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic issue_rd(input logic [4:0] rd);
      idle();
      issue_valid_i = 1; issue_rd_wren_i = 1; issue_rd_addr_i = rd;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      wb_wren_i = 1; wb_addr_i = a; wb_data_i = d;
   endtask

   task automatic use_rs1(input logic [4:0] a);
      issue_valid_i = 1; rs1_used_i = 1; rs1_addr_i = a;
   endtask

   initial begin
      idle();
      rst_i = 1;
      rs1_addr_i = 5;
      #3;
      chk("rst_rs1", rs1_data_o, 32'h0);
      chk("rst_rs2", rs2_data_o, 32'h0);
      chk("rst_stall", {31'b0, stall_o}, 32'h0);
      chk("rst_err", {31'b0, sb_err_o}, 32'h0);
      #14 rst_i = 0;
      tick();

      // write 7 with bypass, then from the array
      issue_rd(7); tick();
      idle(); wb(7, 32'hDEADBEEF); rs1_addr_i = 7; settle();
      chk("bypass_rs1", rs1_data_o, 32'hDEADBEEF);
      tick();
      idle(); rs1_addr_i = 7; settle();
      chk("array_rs1", rs1_data_o, 32'hDEADBEEF);
      chk("err_after_7", {31'b0, sb_err_o}, 32'h0);

      // RAW hazard on x3
      issue_rd(3); tick();
      idle(); use_rs1(3); settle();
      chk("raw3_stall", {31'b0, stall_o}, 32'h1);
      tick();
      chk("raw3_stall_held", {31'b0, stall_o}, 32'h1);
      idle(); use_rs1(3); issue_rd_wren_i = 1; issue_rd_addr_i = 3; wb(3, 32'h55); settle();
      chk("raw3_wb_nostall", {31'b0, stall_o}, 32'h0);
      chk("raw3_wb_bypass", rs1_data_o, 32'h55);
      tick();
      idle(); use_rs1(3); settle();
      chk("raw3_reissued", {31'b0, stall_o}, 32'h1);
      idle(); wb(3, 32'h66); tick();
      idle(); use_rs1(3); settle();
      chk("raw3_clear", {31'b0, stall_o}, 32'h0);
      chk("raw3_data", rs1_data_o, 32'h66);

      // Saturate x4 at 3 in-flight writes
      for (int k = 0; k < 3; k++) begin
         issue_rd(4); settle();
         chk("sat4_fill", {31'b0, stall_o}, 32'h0);
         tick();
      end
      issue_rd(4); settle();
      chk("sat4_full", {31'b0, stall_o}, 32'h1);
      wb(4, 32'h44); settle();
      chk("sat4_wb_lift", {31'b0, stall_o}, 32'h0);
      tick();
      issue_rd(4); settle();
      chk("sat4_still_full", {31'b0, stall_o}, 32'h1);
      kill_valid_i = 1; kill_rd_addr_i = 4; settle();
      chk("sat4_kill_lift", {31'b0, stall_o}, 32'h0);
      tick();
      for (int k = 0; k < 3; k++) begin
         idle(); wb(4, 32'h40 + k); tick();
      end
      idle(); use_rs1(4); settle();
      chk("sat4_drained", {31'b0, stall_o}, 32'h0);
      chk("sat4_data", rs1_data_o, 32'h42);
      chk("err_after_4", {31'b0, sb_err_o}, 32'h0);

      // Kill on x9, then underflow
      issue_rd(9); tick();
      idle(); issue_valid_i = 1; rs2_used_i = 1; rs2_addr_i = 9; settle();
      chk("k9_stall", {31'b0, stall_o}, 32'h1);
      idle(); kill_valid_i = 1; kill_rd_addr_i = 9; tick();
      idle(); issue_valid_i = 1; rs2_used_i = 1; rs2_addr_i = 9; settle();
      chk("k9_nostall", {31'b0, stall_o}, 32'h0);
      chk("k9_err_clean", {31'b0, sb_err_o}, 32'h0);
      idle(); kill_valid_i = 1; kill_rd_addr_i = 9; tick();
      idle(); settle();
      chk("k9_underflow_err", {31'b0, sb_err_o}, 32'h1);
      issue_rd(9); tick();
      idle(); issue_valid_i = 1; rs2_used_i = 1; rs2_addr_i = 9; settle();
      chk("k9_clamped_zero", {31'b0, stall_o}, 32'h1);
      idle(); wb(9, 32'h99); tick();

      // x0 behaviour
      idle(); wb(0, 32'h1234); settle();
      chk("x0_bypass_rs1", rs1_data_o, 32'h0);
      chk("x0_bypass_rs2", rs2_data_o, 32'h0);
      tick();
      idle(); settle();
      chk("x0_read", rs1_data_o, 32'h0);
      issue_rd(0); use_rs1(0); rs2_used_i = 1; settle();
      chk("x0_nostall", {31'b0, stall_o}, 32'h0);
      tick();

      // Async reset with live state
      issue_rd(20); tick();
      idle(); wb(20, 32'hA5A5A5A5); tick();
      issue_rd(12); tick();
      idle(); rs1_addr_i = 20; settle();
      chk("pre_rst_data", rs1_data_o, 32'hA5A5A5A5);
      rst_i = 1; settle();
      chk("async_rst_data", rs1_data_o, 32'h0);
      chk("async_rst_err", {31'b0, sb_err_o}, 32'h0);
      use_rs1(12); settle();
      chk("async_rst_cnt", {31'b0, stall_o}, 32'h0);
      rst_i = 0;
      tick();
      idle(); use_rs1(12); settle();
      chk("post_rst_cnt", {31'b0, stall_o}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_scoreboard.md
Name: regfile_wb_scoreboard

Overview:
- Consumer side of the stage-4 writeback interface: the 32x32 integer register file plus a per-register pending-write scoreboard.
- Accepts the registered writeback triple (wren, rd address, data) and provides two combinational read ports with same-cycle write-through bypass.
- Tracks in-flight destination writes issued from decode and raises a stall when a source register still awaits writeback.
- Sits between decode/issue and the stage-4 pipeline register.

Parameters:
- PEND_W, 2, width of the per-register in-flight counter; max in-flight writes per register = 2^PEND_W-1.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- wb_wren_i  input  1  writeback enable from the stage-4 register.
- wb_addr_i  input  5  writeback destination register.
- wb_data_i  input  32  writeback data.
- rs1_addr_i  input  5  read port 1 address.
- rs2_addr_i  input  5  read port 2 address.
- rs1_data_o  output  32  read port 1 data, combinational.
- rs2_data_o  output  32  read port 2 data, combinational.
- issue_valid_i  input  1  decode presents an instruction for issue.
- issue_rd_wren_i  input  1  that instruction writes rd.
- issue_rd_addr_i  input  5  that instruction's rd.
- rs1_used_i  input  1  instruction reads rs1.
- rs2_used_i  input  1  instruction reads rs2.
- kill_valid_i  input  1  an issued, not-yet-written-back instruction is squashed (mispredict).
- kill_rd_addr_i  input  5  rd of the squashed instruction; asserted only for instructions that had rd_wren.
- stall_o  output  1  issue blocked this cycle, combinational.
- sb_err_o  output  1  sticky scoreboard underflow/overflow flag.

Behaviour:
- Reset (async, rst_i=1): all 32 registers = 0; all counters = 0; sb_err_o = 0. Read outputs follow combinationally: 0 in reset.
- x0: writes ignored; reads return 0; never pending; never causes stall; issue/kill/wb to x0 do not touch counters.
- Write: on clock edge with wb_wren_i=1 and wb_addr_i!=0, reg[wb_addr_i] <= wb_data_i.
- Read: rsN_data_o = 0 if addr=0; else wb_data_i if wb_wren_i and wb_addr_i==addr (bypass); else reg[addr].
- Source hazard for rsN, when rsN_used_i and addr!=0:
  - count[addr] >= 2, or
  - count[addr] == 1 without a same-cycle writeback to addr (wb_wren_i and wb_addr_i==addr).
- Dest hazard: issue_rd_wren_i, rd!=0, count[rd] at max (2^PEND_W-1), and no same-cycle wb/kill to rd.
- stall_o = issue_valid_i and (any source hazard or dest hazard).
- Issue accepted = issue_valid_i and not stall_o. If accepted with issue_rd_wren_i and rd!=0, increment count[rd].
- Decrement count[wb_addr_i] on wb_wren_i (addr!=0). Decrement count[kill_rd_addr_i] on kill_valid_i (addr!=0).
- Simultaneous events on one register combine as net delta (+1 issue, -1 wb, -1 kill). Range is -2..+1.
- Underflow: result clamps to 0 and sets sb_err_o. Register data is still written.
- Overflow: prevented by dest hazard; if reached anyway, result clamps at max and sets sb_err_o.
- sb_err_o clears only on reset.
- Latency: writeback visible to readers in the same cycle via bypass and from register state next cycle. Stall is a pure function of current inputs and counters.
- Reset mid-operation clears all counters and data immediately; in-flight writebacks after reset release underflow silently? No: they set sb_err_o. Upstream flushes the pipeline on reset.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> both outputs 0; stall_o=0; sb_err_o=0.
- wb_wren=1, addr=7, data=0xDEADBEEF, rs1_addr=7 same cycle -> rs1_data_o=0xDEADBEEF (bypass); next cycle without wb, rs1_data_o=0xDEADBEEF from the array.
- Issue rd=3 accepted; next cycle issue using rs1=3 with no wb -> stall_o=1, count unchanged. Then wb to 3 the same cycle as issue -> stall_o=0, rs1_data_o=wb data, count[3] 1->0 (or 1 if new issue writes 3).
- Issue rd=4 three times (count=3), then a 4th issue writing 4 -> stall_o=1. A same-cycle wb to 4 lifts stall, count stays 3.
- Issue rd=9, then kill_valid with rd=9 -> count[9]=0, no stall on a subsequent rs2=9 read. A further kill on 9 -> sb_err_o=1, count stays 0.
- wb to x0 with data 0x1234 -> reading x0 returns 0; no counter change. Assert rst_i mid-sequence with counters nonzero -> all counters and registers 0 asynchronously.
